// File: rtl/change_dispenser_if.sv
// Payout bus for the change dispenser: start/amount request, coin offer handshake,
// refill inputs and status/stock outputs.
interface change_dispenser_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [5:0]       amount;
    logic             coin_ack;
    logic             refill;
    logic [CNT_W-1:0] refill_n25;
    logic [CNT_W-1:0] refill_n10;
    logic [CNT_W-1:0] refill_n5;
    logic             busy;
    logic             coin_valid;
    logic [1:0]       coin;
    logic             done;
    logic             short;
    logic [5:0]       remaining;
    logic [CNT_W-1:0] stock_n25;
    logic [CNT_W-1:0] stock_n10;
    logic [CNT_W-1:0] stock_n5;

    modport master (
        output start, amount, coin_ack, refill, refill_n25, refill_n10, refill_n5,
        input  busy, coin_valid, coin, done, short, remaining,
               stock_n25, stock_n10, stock_n5
    );

    modport slave (
        input  start, amount, coin_ack, refill, refill_n25, refill_n10, refill_n5,
        output busy, coin_valid, coin, done, short, remaining,
               stock_n25, stock_n10, stock_n5
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout from finite coin stock; one coin offered at a time over valid/ack.
// First coin 2 edges after start; each further coin 1 SELECT cycle after the previous ack.
module change_dispenser #(
    parameter int CNT_W    = 4,
    parameter int INIT_N25 = 4,
    parameter int INIT_N10 = 4,
    parameter int INIT_N5  = 4
) (
    input  logic clk,
    input  logic rst,
    change_dispenser_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_OFFER  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0]       C_NONE = 2'b00;
    localparam logic [1:0]       C_5    = 2'b01;
    localparam logic [1:0]       C_10   = 2'b10;
    localparam logic [1:0]       C_25   = 2'b11;
    localparam logic [CNT_W-1:0] ONE    = 1;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_coin;
    logic [1:0]       w_pick;
    logic [5:0]       w_coin_val;
    logic [5:0]       r_remaining;
    logic             r_short;
    logic [CNT_W-1:0] r_n25;
    logic [CNT_W-1:0] r_n10;
    logic [CNT_W-1:0] r_n5;
    logic             w_refill_en;
    logic             w_ack_en;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        w_pick = C_NONE;
        if (r_remaining >= 6'd25 && r_n25 != '0)
            w_pick = C_25;
        else if (r_remaining >= 6'd10 && r_n10 != '0)
            w_pick = C_10;
        else if (r_remaining >= 6'd5 && r_n5 != '0)
            w_pick = C_5;
    end

    always_comb begin
        w_coin_val = 6'd0;
        case (r_coin)
            C_5:     w_coin_val = 6'd5;
            C_10:    w_coin_val = 6'd10;
            C_25:    w_coin_val = 6'd25;
            default: w_coin_val = 6'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_SELECT;
            S_SELECT: w_next = (w_pick != C_NONE) ? S_OFFER : S_DONE;
            S_OFFER:  if (bus.coin_ack) w_next = S_SELECT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    assign w_refill_en = (r_state == S_IDLE) && bus.refill;
    assign w_ack_en    = (r_state == S_OFFER) && bus.coin_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coin      <= C_NONE;
            r_remaining <= 6'd0;
            r_short     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_remaining <= bus.amount;
                    r_short     <= 1'b0;
                end
                S_SELECT: r_coin <= w_pick;
                // selection guarantees remaining >= coin value, so no underflow
                S_OFFER:  if (bus.coin_ack) r_remaining <= r_remaining - w_coin_val;
                S_DONE:   r_short <= (r_remaining != 6'd0);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n25 <= CNT_W'(INIT_N25);
            r_n10 <= CNT_W'(INIT_N10);
            r_n5  <= CNT_W'(INIT_N5);
        end else if (w_refill_en) begin
            r_n25 <= sat_add(r_n25, bus.refill_n25);
            r_n10 <= sat_add(r_n10, bus.refill_n10);
            r_n5  <= sat_add(r_n5,  bus.refill_n5);
        end else if (w_ack_en) begin
            case (r_coin)
                C_25:    r_n25 <= r_n25 - ONE;
                C_10:    r_n10 <= r_n10 - ONE;
                C_5:     r_n5  <= r_n5  - ONE;
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.coin_valid = (r_state == S_OFFER);
    assign bus.coin       = (r_state == S_OFFER) ? r_coin : C_NONE;
    assign bus.done       = (r_state == S_DONE);
    assign bus.short      = r_short;
    assign bus.remaining  = r_remaining;
    assign bus.stock_n25  = r_n25;
    assign bus.stock_n10  = r_n10;
    assign bus.stock_n5   = r_n5;
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change as a serial stream of coin codes after a sale; the coin-out counterpart of the coin-accepting vending FSM.
- Uses the same 2-bit coin encoding as the vending FSM: 00 = none, 01 = 5, 10 = 10, 11 = 25.
- Receives a change amount, chooses coins greedily from a finite per-denomination stock, and offers one coin at a time to the ejector mechanism over a valid/ack handshake.
- Reports completion, any shortfall, and live stock counts.

Parameters:
- CNT_W, 4, width of each stock counter; counters saturate at 2^CNT_W-1.
- INIT_N25, 4, stock of 25-unit coins after reset.
- INIT_N10, 4, stock of 10-unit coins after reset.
- INIT_N5, 4, stock of 5-unit coins after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request payout of amount; honoured only when busy=0.
- amount  input  6  change value in units, 0..63.
- coin_ack  input  1  ejector has taken the offered coin.
- refill  input  1  add refill counts to stock; honoured only in IDLE.
- refill_n25  input  CNT_W  25-unit coins to add.
- refill_n10  input  CNT_W  10-unit coins to add.
- refill_n5  input  CNT_W  5-unit coins to add.
- busy  output  1  payout in progress (any state other than IDLE).
- coin_valid  output  1  a coin is being offered.
- coin  output  2  code of the offered coin; 00 when coin_valid=0.
- done  output  1  one-cycle pulse at the end of a payout.
- short  output  1  registered; 1 = last payout could not be completed.
- remaining  output  6  registered; value not yet paid.
- stock_n25  output  CNT_W  current stock of 25-unit coins.
- stock_n10  output  CNT_W  current stock of 10-unit coins.
- stock_n5  output  CNT_W  current stock of 5-unit coins.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; busy, coin_valid, done, short = 0; coin = 00; remaining = 0.
  - stock counters = INIT_N25 / INIT_N10 / INIT_N5.
  - Reset mid-payout abandons the payout; no coin is decremented for an un-acked offer.
- States: IDLE, SELECT, OFFER, DONE.
- IDLE:
  - start=1 loads remaining<=amount, clears short, and moves to SELECT on the next edge.
  - refill=1 adds each refill count to its stock, saturating at 2^CNT_W-1.
  - refill and start in the same cycle: both take effect; SELECT sees the refilled stock.
- SELECT (exactly 1 cycle; greedy choice):
  - Pick 25 if remaining>=25 and stock_n25>0.
  - Else pick 10 if remaining>=10 and stock_n10>0.
  - Else pick 5 if remaining>=5 and stock_n5>0.
  - If a coin is picked, go to OFFER with that code.
  - If none is picked, go to DONE.
- OFFER:
  - coin_valid=1; coin holds the chosen code, stable until ack.
  - coin_ack=1 at a rising edge completes the transfer:
    - the matching stock is decremented;
    - remaining is decreased by the coin value;
    - the FSM returns to SELECT.
  - No timeout; the FSM holds in OFFER indefinitely without ack.
  - coin_ack outside OFFER is ignored.
- DONE:
  - done=1 for exactly one cycle.
  - short<=(remaining!=0); short and remaining hold until the next accepted start.
  - Returns to IDLE.
- Arithmetic and signalling rules:
  - remaining is unsigned and never underflows, because selection guarantees remaining >= coin value.
  - A residue below 5 (amount not a multiple of 5) is left in remaining and flags short.
  - amount=0: IDLE -> SELECT -> DONE with short=0, no coin offered; done occurs 2 cycles after start.
- Latency:
  - First coin_valid appears 2 edges after start is sampled.
  - Each additional coin takes 1 SELECT cycle after its predecessor's ack.
- start during busy=1 and refill outside IDLE are ignored with no side effects.
- Greedy order is fixed. A payout that is solvable non-greedily but fails greedily (e.g. 30 with 25s available and no 5s) ends short; this is accepted behaviour.

Test Plan:
- Reset, then amount=20 start, ack every offer -> coins 10,10; done pulse; short=0; remaining=0; stock_n10=2.
- amount=45 with default stock, ack held low 3 cycles on the first offer -> coin=11 stays stable while unacked; sequence 25,10,10; stock_n25=3, stock_n10=2; short=0.
- After stock_n5 has been drained to 0 by repeated amount=5 payouts, amount=5 -> no coin offered, done pulse, short=1, remaining=5.
- amount=7 -> single coin 01, then done with short=1, remaining=2.
- In IDLE, refill with n25=15 (stock 4) in the same cycle as start amount=50 -> stock_n25 saturates to 15; coins 25,25; final stock_n25=13.
- Assert rst while in OFFER after one acked coin of a 40 payout -> all outputs return to reset values immediately; stock returns to INIT; a start during the earlier busy period had no effect.
